// File: rtl/opfetch_pkg.sv
// Shared register-file geometry for the operand fetch unit, RegisterFile and writeback stage.
// Single-cycle defaults only; no logic lives here.
package opfetch_pkg;
    localparam int DATA_W    = 32;
    localparam int REG_DEPTH = 32;
    localparam int REG_AW    = $clog2(REG_DEPTH);

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/opfetch_scoreboard.sv
// Per-register busy vector: set on issue, clear on writeback, set wins on collision.
// Lookups are combinational from the registered vector; register 0 is never busy.
module opfetch_scoreboard #(
    parameter int REG_DEPTH = 32,
    parameter int AW        = $clog2(REG_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_vld,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_vld,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] lk1_addr,
    output logic          lk1_busy,
    input  logic [AW-1:0] lk2_addr,
    output logic          lk2_busy,
    input  logic [AW-1:0] lk3_addr,
    output logic          lk3_busy
);
    logic [REG_DEPTH-1:0] busy_q;
    logic [REG_DEPTH-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_vld && clr_addr != '0) busy_d[clr_addr] = 1'b0;
        // Applied after the clear so a same-cycle set of the same register survives.
        if (set_vld && set_addr != '0) busy_d[set_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign lk1_busy = busy_q[lk1_addr];
    assign lk2_busy = busy_q[lk2_addr];
    assign lk3_busy = busy_q[lk3_addr];
endmodule

// File: rtl/operand_fetch_unit.sv
// Operand fetch: RegisterFile read, RAW/WAW scoreboard stall, 1-cycle output register to execute.
// Optional writeback bypass when OPFETCH_BYPASS_EN is defined; stalls decode while the output is held.
module operand_fetch_unit
    import opfetch_pkg::*;
#(
    parameter int DATA_W    = opfetch_pkg::DATA_W,
    parameter int REG_DEPTH = opfetch_pkg::REG_DEPTH,
    parameter int CNT_W     = 16,
    localparam int AW       = $clog2(REG_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [AW-1:0]     dec_rs1,
    input  logic [AW-1:0]     dec_rs2,
    input  logic [AW-1:0]     dec_rd,
    input  logic              dec_rd_we,
    output logic [AW-1:0]     A_select,
    output logic [AW-1:0]     B_select,
    input  logic [DATA_W-1:0] A_out,
    input  logic [DATA_W-1:0] B_out,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_op_b,
    output logic [AW-1:0]     ex_rd,
    output logic              ex_rd_we,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] ex_op_a_q, ex_op_a_d;
    logic [DATA_W-1:0] ex_op_b_q, ex_op_b_d;
    logic [AW-1:0]     ex_rd_q, ex_rd_d;
    logic              ex_rd_we_q, ex_rd_we_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic rs1_nz, rs2_nz, rd_nz;
    logic busy1, busy2, busy_rd;
    logic byp1, byp2;
    logic hazard, out_free, fire;

    assign rs1_nz = dec_rs1 != '0;
    assign rs2_nz = dec_rs2 != '0;
    assign rd_nz  = dec_rd  != '0;

    assign A_select = dec_rs1;
    assign B_select = dec_rs2;

`ifdef OPFETCH_BYPASS_EN
    assign byp1 = wb_we && (wb_addr == dec_rs1) && rs1_nz;
    assign byp2 = wb_we && (wb_addr == dec_rs2) && rs2_nz;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    opfetch_scoreboard #(.REG_DEPTH(REG_DEPTH), .AW(AW)) u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_vld  (fire && dec_rd_we),
        .set_addr (dec_rd),
        .clr_vld  (wb_we),
        .clr_addr (wb_addr),
        .lk1_addr (dec_rs1),
        .lk1_busy (busy1),
        .lk2_addr (dec_rs2),
        .lk2_busy (busy2),
        .lk3_addr (dec_rd),
        .lk3_busy (busy_rd)
    );

    // WAW: a write already in flight to rd blocks issue unless it retires this very cycle.
    assign hazard = (busy1 && rs1_nz && !byp1)
                 || (busy2 && rs2_nz && !byp2)
                 || (dec_rd_we && rd_nz && busy_rd && !(wb_we && wb_addr == dec_rd));

    assign out_free  = !ex_valid_q || ex_ready;
    assign dec_ready = out_free && !hazard;
    assign fire      = dec_valid && dec_ready;

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_op_a_d   = ex_op_a_q;
        ex_op_b_d   = ex_op_b_q;
        ex_rd_d     = ex_rd_q;
        ex_rd_we_d  = ex_rd_we_q;
        stall_cnt_d = stall_cnt_q;
        if (fire) begin
            ex_valid_d = 1'b1;
            ex_op_a_d  = !rs1_nz ? '0 : (byp1 ? wb_data : A_out);
            ex_op_b_d  = !rs2_nz ? '0 : (byp2 ? wb_data : B_out);
            ex_rd_d    = dec_rd;
            ex_rd_we_d = dec_rd_we;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
        if (dec_valid && out_free && hazard && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid_q  <= 1'b0;
            ex_op_a_q   <= '0;
            ex_op_b_q   <= '0;
            ex_rd_q     <= '0;
            ex_rd_we_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_op_a_q   <= ex_op_a_d;
            ex_op_b_q   <= ex_op_b_d;
            ex_rd_q     <= ex_rd_d;
            ex_rd_we_q  <= ex_rd_we_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_op_a   = ex_op_a_q;
    assign ex_op_b   = ex_op_b_q;
    assign ex_rd     = ex_rd_q;
    assign ex_rd_we  = ex_rd_we_q;
    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_operand_fetch_unit.sv
// Randomized bench for operand_fetch_unit against a transaction-level model with a RegisterFile array.
// Define OPFETCH_BYPASS_EN for both bench and RTL to exercise the bypass build.
module tb_operand_fetch_unit;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;
`ifdef OPFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          dec_valid, dec_ready, dec_rd_we;
    logic [AW-1:0] dec_rs1, dec_rs2, dec_rd, A_select, B_select, wb_addr, ex_rd;
    logic [DW-1:0] A_out, B_out, wb_data, ex_op_a, ex_op_b;
    logic          wb_we, ex_valid, ex_ready, ex_rd_we;
    logic [CW-1:0] stall_cnt;

    logic [DW-1:0] rf [32];
    assign A_out = rf[A_select];
    assign B_out = rf[B_select];

    always #5 clk = ~clk;

    operand_fetch_unit #(.DATA_W(DW), .REG_DEPTH(32), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_rd_we(dec_rd_we),
        .A_select(A_select), .B_select(B_select), .A_out(A_out), .B_out(B_out),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .stall_cnt(stall_cnt)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Reference state: which registers have a write outstanding, and what execute holds.
    bit            m_busy [32];
    bit            m_vld, m_rdwe;
    logic [DW-1:0] m_a, m_b;
    int            m_rd, m_cnt;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // One clock: drive inputs, check the decode-side response, clock, then check the execute side.
    task automatic step(input bit rst_n, input bit dv, input int r1, input int r2, input int rdd,
                        input bit we, input bit exr, input bit wbw, input int wba,
                        input logic [DW-1:0] wbd);
        bit haz, free, rdy, fire, bp1, bp2;
        logic [DW-1:0] na, nb;
        reset     = rst_n;
        dec_valid = dv;
        dec_rs1   = AW'(r1);
        dec_rs2   = AW'(r2);
        dec_rd    = AW'(rdd);
        dec_rd_we = we;
        ex_ready  = exr;
        wb_we     = wbw;
        wb_addr   = AW'(wba);
        wb_data   = wbd;
        #1;
        bp1  = BYP && wbw && wba == r1 && r1 != 0;
        bp2  = BYP && wbw && wba == r2 && r2 != 0;
        haz  = (r1 != 0 && m_busy[r1] && !bp1) || (r2 != 0 && m_busy[r2] && !bp2)
            || (we && rdd != 0 && m_busy[rdd] && !(wbw && wba == rdd));
        free = !m_vld || exr;
        rdy  = free && !haz;
        fire = dv && rdy;
        na   = (r1 == 0) ? '0 : (bp1 ? wbd : rf[r1]);
        nb   = (r2 == 0) ? '0 : (bp2 ? wbd : rf[r2]);
        if (rst_n) begin
            check_eq("dec_ready", 64'(dec_ready), 64'(rdy));
            check_eq("A_select", 64'(A_select), 64'(r1));
            check_eq("B_select", 64'(B_select), 64'(r2));
        end
        @(posedge clk);
        #1;
        if (wbw) rf[wba] = wbd;
        if (!rst_n) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_vld = 0; m_rdwe = 0; m_a = '0; m_b = '0; m_rd = 0; m_cnt = 0;
        end else begin
            if (dv && free && haz && m_cnt < 65535) m_cnt++;
            if (wbw && wba != 0) m_busy[wba] = 1'b0;
            if (fire && we && rdd != 0) m_busy[rdd] = 1'b1;
            if (fire) begin
                m_vld = 1; m_a = na; m_b = nb; m_rd = rdd; m_rdwe = we;
            end else if (exr) begin
                m_vld = 0;
            end
        end
        check_eq("ex_valid", 64'(ex_valid), 64'(m_vld));
        check_eq("ex_op_a", 64'(ex_op_a), 64'(m_a));
        check_eq("ex_op_b", 64'(ex_op_b), 64'(m_b));
        check_eq("ex_rd", 64'(ex_rd), 64'(m_rd));
        check_eq("ex_rd_we", 64'(ex_rd_we), 64'(m_rdwe));
        check_eq("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, '0);
    endtask

    initial begin
        int base;
        int bq[$];
        for (int i = 0; i < 32; i++) rf[i] = DW'(i);

        // Reset held low with random decode traffic.
        for (int i = 0; i < 3; i++)
            step(0, 1'($urandom), int'($urandom_range(31)), int'($urandom_range(31)),
                 int'($urandom_range(31)), 1'($urandom), 1'($urandom), 0, 0, $urandom);
        check_eq("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        idle();

        // Plain read: x5 and x31, rd=0 with write enable never marks busy.
        step(1, 1, 5, 31, 0, 1, 1, 0, 0, '0);
        check_eq("t2_op_a", 64'(ex_op_a), 64'd5);
        check_eq("t2_op_b", 64'(ex_op_b), 64'd31);
        check_eq("t2_rd_we", 64'(ex_rd_we), 64'd1);
        idle();

        // RAW on x7 resolved by writeback of 0xDEAD.
        step(1, 1, 0, 0, 7, 1, 1, 0, 0, '0);
        base = m_cnt;
        step(1, 1, 7, 0, 0, 0, 1, 0, 0, '0);
        step(1, 1, 7, 0, 0, 0, 1, 1, 7, 32'hDEAD);
        if (!BYP) step(1, 1, 7, 0, 0, 0, 1, 0, 0, '0);
        check_eq("t3_valid", 64'(ex_valid), 64'd1);
        check_eq("t3_op_a", 64'(ex_op_a), 64'hDEAD);
        check_eq("t3_stalls", 64'(stall_cnt), 64'(base + (BYP ? 1 : 2)));
        idle();

        // Register 0: write to x0 neither bypasses nor stalls.
        step(1, 1, 0, 0, 0, 1, 1, 1, 0, 32'hFFFF);
        check_eq("t4_op_a", 64'(ex_op_a), 64'd0);
        step(1, 1, 0, 0, 0, 1, 1, 0, 0, '0);
        check_eq("t4_no_busy", 64'(ex_valid), 64'd1);
        idle();

        // Execute backpressure for 4 cycles.
        step(1, 1, 1, 2, 0, 0, 1, 0, 0, '0);
        base = m_cnt;
        for (int i = 0; i < 4; i++) step(1, 1, 3, 4, 0, 0, 0, 0, 0, '0);
        check_eq("t5_op_a", 64'(ex_op_a), 64'd1);
        check_eq("t5_stall_hold", 64'(stall_cnt), 64'(base));
        idle();

        // Issue rd=3 in the cycle a writeback to x3 lands: x3 must end busy.
        step(1, 1, 0, 0, 3, 1, 1, 1, 3, 32'h33);
        step(1, 1, 0, 3, 0, 0, 1, 0, 0, '0);
        check_eq("t6_stalled", 64'(ex_valid), 64'd0);
        step(1, 0, 0, 0, 0, 0, 1, 1, 3, 32'h3333);

        // Random traffic over a small register window to provoke hazards.
        for (int c = 0; c < 3000; c++) begin
            bit wbw;
            int wba;
            bq.delete();
            for (int i = 1; i < 32; i++) if (m_busy[i]) bq.push_back(i);
            wbw = ($urandom_range(2) == 0);
            if (bq.size() > 0) wba = bq[$urandom_range(bq.size() - 1)];
            else               wba = int'($urandom_range(7));
            step(($urandom_range(249) != 0), ($urandom_range(3) != 0),
                 int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom_range(7)),
                 1'($urandom), ($urandom_range(3) != 0), wbw, wba, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
